nowtime_setter: RTL and testbench

- User-facing time editor; the writer side of the BCD time-of-day register (HH:MM:SS, 24-bit packed BCD, [23:20]=hour tens … [3:0]=second ones).
- Snapshots the running time and lets buttons select and adjust the hour, minute and second fields with BCD wrap-around.
- On confirm, drives save_nowtime and a one-cycle save_nowtime_yet load pulse into the time counter.

---
 rtl/nowtime_setter_if.sv | 23 ++
 rtl/nowtime_setter.sv | 121 ++++++++++++
 tb/tb_nowtime_setter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/nowtime_setter_if.sv
// nowtime_setter_if: time/button bus between the time editor and its environment.
interface nowtime_setter_if;
    logic [23:0] nowtime;
    logic        edit_en;
    logic        btn_sel;
    logic        btn_inc;
    logic        btn_dec;
    logic        btn_ok;
    logic [23:0] save_nowtime;
    logic        save_nowtime_yet;
    logic [1:0]  edit_field;
    logic        editing;

    modport master (
        output nowtime, edit_en, btn_sel, btn_inc, btn_dec, btn_ok,
        input  save_nowtime, save_nowtime_yet, edit_field, editing
    );

    modport slave (
        input  nowtime, edit_en, btn_sel, btn_inc, btn_dec, btn_ok,
        output save_nowtime, save_nowtime_yet, edit_field, editing
    );
endinterface

// File: rtl/nowtime_setter.sv
// nowtime_setter: BCD HH:MM:SS time editor with field select, inc/dec and commit strobe.
// Define AUTO_REPEAT_EN to add held-button auto-repeat for inc/dec.
module nowtime_setter #(
    parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1000000
) (
    input logic             clk,
    input logic             rst_n,
    nowtime_setter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

    state_t      state_q;
    logic [4:0]  s1_q, s2_q, p_q, rise;
    logic [23:0] work_q, work_d, save_q;
    logic        yet_q, editing_q;
    logic [1:0]  field_q;
    logic [7:0]  cur, nxt;
    logic        inc_go, dec_go;

    // bit order {ok, dec, inc, sel, edit_en}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            p_q  <= '0;
        end else begin
            s1_q <= {bus.btn_ok, bus.btn_dec, bus.btn_inc, bus.btn_sel, bus.edit_en};
            s2_q <= s1_q;
            p_q  <= s2_q;
        end
    end

    assign rise = s2_q & ~p_q;

    // Digits are compared as a binary byte, valid because each nibble is already checked <= 9.
    function automatic logic [7:0] bcd_step(input logic [7:0] f, input logic hr, input logic up);
        logic [7:0] top;
        top = hr ? 8'h23 : 8'h59;
        if (f[3:0] > 4'd9 || f[7:4] > 4'd9 || f > top) return 8'h00;
        if (up) return (f == top) ? 8'h00 : (f[3:0] == 4'd9) ? {f[7:4] + 4'd1, 4'd0} : f + 8'd1;
        return (f == 8'h00) ? top : (f[3:0] == 4'd0) ? {f[7:4] - 4'd1, 4'd9} : f - 8'd1;
    endfunction

    assign cur    = (field_q == 2'd1) ? work_q[23:16] : (field_q == 2'd2) ? work_q[15:8] : work_q[7:0];
    assign nxt    = bcd_step(cur, field_q == 2'd1, inc_go);
    assign work_d = (field_q == 2'd1) ? {nxt, work_q[15:0]} :
                    (field_q == 2'd2) ? {work_q[23:16], nxt, work_q[7:0]} : {work_q[23:8], nxt};

`ifdef AUTO_REPEAT_EN
    logic [23:0] hold_inc_q, hold_dec_q;
    logic        rep_inc, rep_dec;

    assign rep_inc = editing_q && s2_q[2] && hold_inc_q == REPEAT_DELAY - 24'd1;
    assign rep_dec = editing_q && s2_q[3] && hold_dec_q == REPEAT_DELAY - 24'd1;

    // after the first repeat the counter restarts one period short of the delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_inc_q <= '0;
            hold_dec_q <= '0;
        end else begin
            hold_inc_q <= (!editing_q || !s2_q[2] || rise[1]) ? '0 :
                          rep_inc ? REPEAT_DELAY - REPEAT_PERIOD : hold_inc_q + 24'd1;
            hold_dec_q <= (!editing_q || !s2_q[3] || rise[1]) ? '0 :
                          rep_dec ? REPEAT_DELAY - REPEAT_PERIOD : hold_dec_q + 24'd1;
        end
    end

    assign inc_go = rise[2] | rep_inc;
    assign dec_go = rise[3] | rep_dec;
`else
    logic unused_par;
    assign unused_par = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign inc_go     = rise[2];
    assign dec_go     = rise[3];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            save_q    <= '0;
            yet_q     <= 1'b0;
            editing_q <= 1'b0;
            field_q   <= 2'd0;
        end else begin
            yet_q <= 1'b0;
            case (state_q)
                IDLE: if (rise[0]) begin
                    work_q    <= bus.nowtime;
                    state_q   <= EDIT_HR;
                    editing_q <= 1'b1;
                    field_q   <= 2'd1;
                end
                COMMIT: state_q <= IDLE;
                default: if (!s2_q[0]) begin
                    state_q   <= IDLE;
                    editing_q <= 1'b0;
                    field_q   <= 2'd0;
                end else if (rise[4]) begin
                    state_q   <= COMMIT;
                    save_q    <= work_q;
                    yet_q     <= 1'b1;
                    editing_q <= 1'b0;
                    field_q   <= 2'd0;
                end else if (rise[1]) begin
                    state_q <= (state_q == EDIT_HR) ? EDIT_MIN : (state_q == EDIT_MIN) ? EDIT_SEC : EDIT_HR;
                    field_q <= (field_q == 2'd3) ? 2'd1 : field_q + 2'd1;
                end else if (inc_go ^ dec_go) begin
                    work_q <= work_d;
                end
            endcase
        end
    end

    assign bus.save_nowtime     = save_q;
    assign bus.save_nowtime_yet = yet_q;
    assign bus.edit_field       = field_q;
    assign bus.editing          = editing_q;
endmodule

// File: tb/tb_nowtime_setter.sv
// tb_nowtime_setter: directed plan plus random stimulus against a cycle-level behavioural model.
module tb_nowtime_setter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    nowtime_setter_if bus ();
    nowtime_setter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // model: inputs sampled at edge k take effect at edge k+2
    logic [4:0]  hist [3] = '{default: '0};
    int          m_state = 0;
    int          m_field = 0;
    logic [23:0] m_work = '0;
    logic [23:0] m_save = '0;
    logic        m_yet = 1'b0;

    function automatic logic [7:0] mstep(input logic [7:0] b, input int modulus, input bit up);
        int t, o, v;
        t = int'(b[7:4]);
        o = int'(b[3:0]);
        v = t * 10 + o;
        if (t > 9 || o > 9 || v >= modulus) return 8'h00;
        v = up ? (v + 1) % modulus : (v + modulus - 1) % modulus;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin : mdl
        logic [4:0] lvl, rs;
        int sh;
        if (!rst_n) begin
            hist    = '{default: '0};
            m_state = 0;
            m_field = 0;
            m_work  = '0;
            m_save  = '0;
            m_yet   = 1'b0;
        end else begin
            lvl   = hist[1];
            rs    = hist[1] & ~hist[2];
            m_yet = 1'b0;
            if (m_state == 2) m_state = 0;
            else if (m_state == 0) begin
                if (rs[0]) begin
                    m_work  = bus.nowtime;
                    m_state = 1;
                    m_field = 1;
                end
            end else if (!lvl[0]) begin
                m_state = 0;
                m_field = 0;
            end else if (rs[4]) begin
                m_save  = m_work;
                m_yet   = 1'b1;
                m_state = 2;
                m_field = 0;
            end else if (rs[1]) m_field = m_field % 3 + 1;
            else if (rs[2] != rs[3]) begin
                sh = (3 - m_field) * 8;
                m_work[sh +: 8] = mstep(m_work[sh +: 8], m_field == 1 ? 24 : 60, rs[2]);
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {bus.btn_ok, bus.btn_dec, bus.btn_inc, bus.btn_sel, bus.edit_en};
        end
    end

    always @(negedge clk) begin
        tests++;
        if (bus.editing !== (m_state == 1) || bus.edit_field !== 2'(m_field) ||
            bus.save_nowtime !== m_save || bus.save_nowtime_yet !== m_yet) begin
            fails++;
            $display("FAIL model_cmp t=%0t: editing=%b field=%0d save=%h yet=%b, expected editing=%b field=%0d save=%h yet=%b",
                     $time, bus.editing, bus.edit_field, bus.save_nowtime, bus.save_nowtime_yet,
                     m_state == 1, m_field, m_save, m_yet);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // m = {ok, dec, inc, sel}
    task automatic set_btn(input logic [3:0] m);
        {bus.btn_ok, bus.btn_dec, bus.btn_inc, bus.btn_sel} = m;
    endtask

    task automatic press(input logic [3:0] m);
        set_btn(m);
        step();
        set_btn(4'b0000);
        step(2);
    endtask

    task automatic enter(input logic [23:0] t, input string nm);
        bus.nowtime = t;
        bus.edit_en = 1'b1;
        step(3);
        chk({nm, " editing"}, 32'(bus.editing), 32'd1);
        chk({nm, " field"}, 32'(bus.edit_field), 32'd1);
    endtask

    task automatic commit(input logic [23:0] exp, input string nm, input logic [3:0] m = 4'b1000);
        press(m);
        chk({nm, " strobe"}, 32'(bus.save_nowtime_yet), 32'd1);
        chk({nm, " save"}, 32'(bus.save_nowtime), 32'(exp));
        chk({nm, " editing_off"}, 32'(bus.editing), 32'd0);
        step();
        chk({nm, " strobe_one_cycle"}, 32'(bus.save_nowtime_yet), 32'd0);
        bus.edit_en = 1'b0;
        step(3);
    endtask

    function automatic logic [23:0] rand_time();
        int h, mi, s;
        h  = int'($urandom_range(0, 23));
        mi = int'($urandom_range(0, 59));
        s  = int'($urandom_range(0, 59));
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        bus.nowtime = '0;
        bus.edit_en = 1'b0;
        set_btn(4'b0000);
        step(2);
        chk("reset editing", 32'(bus.editing), 32'd0);
        chk("reset field", 32'(bus.edit_field), 32'd0);
        chk("reset save", 32'(bus.save_nowtime), 32'd0);
        chk("reset strobe", 32'(bus.save_nowtime_yet), 32'd0);
        rst_n = 1'b1;
        step(2);

        enter(24'h123456, "plain");
        commit(24'h123456, "plain");

        enter(24'h233456, "hour");
        press(4'b0010);
        press(4'b0100);
        press(4'b0100);
        commit(24'h223456, "hour");

        enter(24'h080059, "minsec");
        press(4'b0001);
        chk("minsec field2", 32'(bus.edit_field), 32'd2);
        press(4'b0100);
        press(4'b0001);
        chk("minsec field3", 32'(bus.edit_field), 32'd3);
        press(4'b0010);
        press(4'b0001);
        chk("minsec field1", 32'(bus.edit_field), 32'd1);
        commit(24'h085900, "minsec");

        enter(24'h101010, "abort");
        press(4'b0010);
        bus.edit_en = 1'b0;
        step(3);
        chk("abort editing", 32'(bus.editing), 32'd0);
        chk("abort field", 32'(bus.edit_field), 32'd0);
        chk("abort save", 32'(bus.save_nowtime), 32'h085900);

        enter(24'h123456, "incdec");
        press(4'b0110);
        commit(24'h123456, "incdec");

        enter(24'h111111, "okinc");
        commit(24'h111111, "okinc", 4'b1010);

        enter(24'h990000, "invalid");
        press(4'b0010);
        commit(24'h000000, "invalid");

        enter(24'h050505, "held");
        set_btn(4'b0010);
        step(12);
        set_btn(4'b0000);
        step(2);
        commit(24'h060505, "held");

        enter(24'h120000, "midreset");
        press(4'b0001);
        chk("midreset field2", 32'(bus.edit_field), 32'd2);
        rst_n       = 1'b0;
        bus.edit_en = 1'b0;
        step();
        chk("midreset editing", 32'(bus.editing), 32'd0);
        chk("midreset field", 32'(bus.edit_field), 32'd0);
        chk("midreset save", 32'(bus.save_nowtime), 32'd0);
        chk("midreset strobe", 32'(bus.save_nowtime_yet), 32'd0);
        rst_n = 1'b1;
        step(2);
        enter(24'h045500, "resnap");
        commit(24'h045500, "resnap");

        repeat (4000) begin
            rst_n = ($urandom_range(0, 699) != 0);
            if ($urandom_range(0, 59) == 0) bus.edit_en = ~bus.edit_en;
            bus.btn_sel = ($urandom_range(0, 4) == 0);
            bus.btn_inc = ($urandom_range(0, 4) == 0);
            bus.btn_dec = ($urandom_range(0, 4) == 0);
            bus.btn_ok  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) bus.nowtime = ($urandom_range(0, 3) == 0) ? 24'($urandom) : rand_time();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
